// File: rtl/i2s_rx_master_ctrl.sv
// Master-mode I2S receiver: derives BCLK/LRCLK from CLK, deserialises ADCDAT
// and hands out left/right pairs over a valid/ready port with sticky overrun.
module i2s_rx_master_ctrl #(
  parameter int wordLength = 16,
  parameter int slotLength = 32,
  parameter int clkDiv     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  ADCDAT,
  output logic                  BCLK,
  output logic                  LRCLK,
  output logic [wordLength-1:0] leftWord,
  output logic [wordLength-1:0] rightWord,
  output logic                  sampleValid,
  input  logic                  sampleReady,
  output logic                  overrun,
  input  logic                  clearOverrun
);

  localparam int DivW = (clkDiv > 1) ? $clog2(clkDiv) : 1;
  localparam int BitW = (slotLength > 1) ? $clog2(slotLength) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(clkDiv - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(slotLength - 1);
  localparam logic [BitW-1:0] WordEnd = BitW'(wordLength);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} stateType;

  stateType              state;
  logic [DivW-1:0]       divCnt;
  logic [BitW-1:0]       bitCnt;
  logic [wordLength-1:0] shiftReg;
  logic [wordLength-1:0] leftHold;
  logic                  pairPending;
  logic                  inWord;
  logic [wordLength-1:0] shiftNext;

  // Bit positions 1..wordLength carry data; position 0 is the I2S one-bit delay.
  assign inWord    = (bitCnt != '0) && (bitCnt <= WordEnd);
  assign shiftNext = {shiftReg[wordLength-2:0], ADCDAT};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      divCnt      <= '0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      leftHold    <= '0;
      pairPending <= 1'b0;
      BCLK        <= 1'b0;
      LRCLK       <= 1'b0;
      leftWord    <= '0;
      rightWord   <= '0;
      sampleValid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pairPending <= 1'b0;
      case (state)
        IDLE: begin
          divCnt <= '0;
          bitCnt <= '0;
          BCLK   <= 1'b0;
          LRCLK  <= 1'b0;
          if (enable) state <= LEFT;
        end
        default: begin
          if (divCnt == DivLast) begin
            divCnt <= '0;
            BCLK   <= ~BCLK;
            if (!BCLK) begin
              if (inWord) shiftReg <= shiftNext;
              if (bitCnt == WordEnd) begin
                if (state == LEFT) leftHold <= shiftNext;
                else pairPending <= 1'b1;
              end
            end else if (bitCnt == BitLast) begin
              bitCnt <= '0;
              if (state == LEFT) begin
                state <= RIGHT;
                LRCLK <= 1'b1;
              end else begin
                state <= enable ? LEFT : IDLE;
                LRCLK <= 1'b0;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
      endcase

      // A pending pair loads if the output slot is free or drains this cycle.
      if (pairPending && (!sampleValid || sampleReady)) begin
        leftWord    <= leftHold;
        rightWord   <= shiftReg;
        sampleValid <= 1'b1;
      end else if (sampleValid && sampleReady) begin
        sampleValid <= 1'b0;
      end

      if (pairPending && sampleValid && !sampleReady) overrun <= 1'b1;
      else if (clearOverrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_master_ctrl.sv
// Directed/randomised bench for i2s_rx_master_ctrl with a behavioural ADC
// that serialises per-frame words and a frame-level timing/data model.
module tb_i2s_rx_master_ctrl;

  localparam int wordLength = 16;
  localparam int slotLength = 32;
  localparam int clkDiv     = 2;
  localparam int frameCyc   = 2 * slotLength * 2 * clkDiv;
  localparam int validLat   = clkDiv + 2 * clkDiv * (slotLength + wordLength) + 1;

  logic                  CLK;
  logic                  RST;
  logic                  enable;
  logic                  ADCDAT;
  logic                  BCLK;
  logic                  LRCLK;
  logic [wordLength-1:0] leftWord;
  logic [wordLength-1:0] rightWord;
  logic                  sampleValid;
  logic                  sampleReady;
  logic                  overrun;
  logic                  clearOverrun;

  int testCount = 0;
  int failCount = 0;

  logic [wordLength-1:0] adcL [0:15];
  logic [wordLength-1:0] adcR [0:15];
  logic [wordLength-1:0] adcWord;
  int   adcFrame;
  int   slotFalls;
  logic lastLr;

  i2s_rx_master_ctrl #(
    .wordLength(wordLength),
    .slotLength(slotLength),
    .clkDiv(clkDiv)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .enable(enable),
    .ADCDAT(ADCDAT),
    .BCLK(BCLK),
    .LRCLK(LRCLK),
    .leftWord(leftWord),
    .rightWord(rightWord),
    .sampleValid(sampleValid),
    .sampleReady(sampleReady),
    .overrun(overrun),
    .clearOverrun(clearOverrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ADC slave: counts BCLK falls since the last LRCLK edge and drives the
  // MSB-first word on falls 1..wordLength, random filler elsewhere.
  always @(negedge BCLK) begin
    #1;
    if (LRCLK !== lastLr) begin
      slotFalls = 0;
      if (LRCLK == 1'b0) adcFrame++;
      lastLr = LRCLK;
    end else begin
      slotFalls++;
    end
    if (slotFalls >= 1 && slotFalls <= wordLength) begin
      adcWord = LRCLK ? adcR[adcFrame % 16] : adcL[adcFrame % 16];
      ADCDAT  = adcWord[wordLength - slotFalls];
    end else begin
      ADCDAT = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int frameBase);
    adcFrame  = frameBase;
    slotFalls = 0;
    lastLr    = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitValid(input int limit);
    int n = 0;
    while (!sampleValid && n < limit) begin
      step();
      n++;
    end
    checkOutput("validWait", 32'(sampleValid), 32'd1);
  endtask

  task automatic waitLr(input logic level, input int limit);
    int n = 0;
    while (LRCLK !== level && n < limit) begin
      step();
      n++;
    end
    checkOutput("lrclkWait", 32'(LRCLK), 32'(level));
  endtask

  task automatic checkPair(input string tag, input int frame);
    checkOutput({tag, "Left"}, 32'(leftWord), 32'(adcL[frame]));
    checkOutput({tag, "Right"}, 32'(rightWord), 32'(adcR[frame]));
  endtask

  initial begin
    int n;
    int firstRise;
    int lrRise;
    int riseCount;
    int highCount;
    logic prevB;

    for (int i = 0; i < 16; i++) begin
      adcL[i] = wordLength'($urandom);
      adcR[i] = wordLength'($urandom);
    end
    adcL[0] = 16'hA5C3;
    adcR[0] = 16'h1234;
    ADCDAT = 1'b0;
    applyStimulus(0);

    // Reset held with enable high
    RST = 1'b1;
    enable = 1'b1;
    sampleReady = 1'b1;
    clearOverrun = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("resetBclk", 32'(BCLK), 32'd0);
    end
    checkOutput("resetLrclk", 32'(LRCLK), 32'd0);
    checkOutput("resetLeft", 32'(leftWord), 32'd0);
    checkOutput("resetRight", 32'(rightWord), 32'd0);
    checkOutput("resetValid", 32'(sampleValid), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);

    // Basic capture with timing of the first frame
    applyStimulus(0);
    RST = 1'b0;
    step();
    n = 0;
    firstRise = -1;
    lrRise = -1;
    riseCount = 0;
    prevB = 1'b0;
    while (!sampleValid && n < 400) begin
      step();
      n++;
      if (BCLK && !prevB) riseCount++;
      if (BCLK && firstRise < 0) firstRise = n;
      if (LRCLK && lrRise < 0) lrRise = n;
      prevB = BCLK;
    end
    checkOutput("validLatency", 32'(n), 32'(validLat));
    checkOutput("firstRise", 32'(firstRise), 32'(clkDiv));
    checkOutput("lrclkRise", 32'(lrRise), 32'(slotLength * 2 * clkDiv));
    checkOutput("riseCount", 32'(riseCount), 32'(slotLength + wordLength + 1));
    checkPair("basic", 0);
    step();
    checkOutput("validPulse", 32'(sampleValid), 32'd0);

    // Backpressure across three frames
    sampleReady = 1'b0;
    repeat (3 * frameCyc) step();
    checkOutput("bpValid", 32'(sampleValid), 32'd1);
    checkOutput("bpOverrun", 32'(overrun), 32'd1);
    checkPair("bpHeld", 1);
    sampleReady = 1'b1;
    step();
    checkOutput("bpConsumed", 32'(sampleValid), 32'd0);
    checkOutput("bpSticky", 32'(overrun), 32'd1);
    sampleReady = 1'b0;
    clearOverrun = 1'b1;
    step();
    checkOutput("bpCleared", 32'(overrun), 32'd0);
    clearOverrun = 1'b0;

    // Ready coincident with a new pair while valid is high
    waitValid(400);
    checkPair("frame4", 4);
    repeat (frameCyc - 1) step();
    checkOutput("holdValid", 32'(sampleValid), 32'd1);
    checkPair("holdStable", 4);
    sampleReady = 1'b1;
    step();
    sampleReady = 1'b0;
    checkOutput("swapValid", 32'(sampleValid), 32'd1);
    checkOutput("swapOverrun", 32'(overrun), 32'd0);
    checkPair("swap", 5);

    // Clear coincident with a fresh overrun: set wins
    repeat (frameCyc - 1) step();
    checkOutput("preOverrun", 32'(overrun), 32'd0);
    clearOverrun = 1'b1;
    step();
    clearOverrun = 1'b0;
    checkOutput("setWins", 32'(overrun), 32'd1);
    checkPair("keptOld", 5);
    sampleReady = 1'b1;
    step();
    checkOutput("drain", 32'(sampleValid), 32'd0);
    clearOverrun = 1'b1;
    step();
    clearOverrun = 1'b0;
    checkOutput("clear2", 32'(overrun), 32'd0);

    // Enable dropped mid-left: frame completes, then idle
    waitLr(1'b0, 300);
    repeat (60) step();
    enable = 1'b0;
    waitValid(400);
    checkPair("lastFrame", 7);
    step();
    checkOutput("lastPulse", 32'(sampleValid), 32'd0);
    repeat (100) step();
    highCount = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (BCLK || LRCLK || sampleValid) highCount++;
    end
    checkOutput("idleQuiet", 32'(highCount), 32'd0);

    // Reset mid-right aborts the frame
    applyStimulus(8);
    enable = 1'b1;
    waitLr(1'b1, 300);
    repeat (30) step();
    RST = 1'b1;
    enable = 1'b0;
    step();
    checkOutput("abortBclk", 32'(BCLK), 32'd0);
    checkOutput("abortLrclk", 32'(LRCLK), 32'd0);
    checkOutput("abortLeft", 32'(leftWord), 32'd0);
    checkOutput("abortRight", 32'(rightWord), 32'd0);
    checkOutput("abortValid", 32'(sampleValid), 32'd0);
    checkOutput("abortOverrun", 32'(overrun), 32'd0);
    RST = 1'b0;
    highCount = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (sampleValid || BCLK) highCount++;
    end
    checkOutput("noPair", 32'(highCount), 32'd0);

    // Restart and capture randomised frames
    applyStimulus(9);
    enable = 1'b1;
    step();
    n = 0;
    while (!sampleValid && n < 400) begin
      step();
      n++;
    end
    checkOutput("restartLatency", 32'(n), 32'(validLat));
    checkPair("restart", 9);
    for (int f = 10; f < 12; f++) begin
      step();
      checkOutput("randPulse", 32'(sampleValid), 32'd0);
      waitValid(frameCyc + 10);
      checkPair("rand", f);
    end
    enable = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
